// File: rtl/vga_frame_sequencer.sv
// ---------------------------------------------------------------------------
// vga_frame_sequencer
// Frame-level controller for the VGA pixel generator. It opens an update
// window at the start of vertical blanking. In that window it accepts one
// fighter position/pose update over valid/ready. The update is committed
// atomically at the next frame start, so a frame never shows a partial update.
// It also keeps the frame counter, the animation-phase counter and a count of
// stale frames.
//
// Optional feature: define VGA_SEQ_PAUSE_EN to add the 'pause' input. While
// pause is high the window does not open, and the animation phase and the
// stale count hold. The frame counter still runs. A commit that is already
// pending still completes.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   hCount, vCount    scan position from the sync generator
//   upd_valid/ready   update handshake (ready is high only while the window is open)
//   upd_p1_x, upd_p2_x, upd_p1_pose, upd_p2_pose   update payload
//   p1_x, p2_x, p1_pose, p2_pose                   live (committed) values
//   frame_start, vblank_start, committed           one-cycle pulses
//   frame_count, anim_phase, stale_count           frame statistics
//   pause             (VGA_SEQ_PAUSE_EN only) freeze window and animation
// ---------------------------------------------------------------------------
module vga_frame_sequencer #(
   parameter int unsigned H_TOTAL       = 800,
   parameter int unsigned V_TOTAL       = 525,
   parameter int unsigned V_BLANK_START = 515,
   parameter int unsigned ANIM_DIV      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
`ifdef VGA_SEQ_PAUSE_EN
   input  logic        pause,
`endif
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [9:0]  upd_p1_x,
   input  logic [9:0]  upd_p2_x,
   input  logic [2:0]  upd_p1_pose,
   input  logic [2:0]  upd_p2_pose,
   output logic [9:0]  p1_x,
   output logic [9:0]  p2_x,
   output logic [2:0]  p1_pose,
   output logic [2:0]  p2_pose,
   output logic        frame_start,
   output logic        vblank_start,
   output logic        committed,
   output logic [15:0] frame_count,
   output logic [2:0]  anim_phase,
   output logic [7:0]  stale_count
);

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      OPEN   = 2'd1,
      HELD   = 2'd2
   } state_t;

   state_t      state;
   logic [9:0]  sh_p1_x;
   logic [9:0]  sh_p2_x;
   logic [2:0]  sh_p1_pose;
   logic [2:0]  sh_p2_pose;
   logic [7:0]  anim_div;

   logic        in_frame;
   logic        start_cond;
   logic        blank_cond;
   logic        handshake;
   logic        pause_c;

`ifdef VGA_SEQ_PAUSE_EN
   assign pause_c = pause;
`else
   assign pause_c = 1'b0;
`endif

   // The range qualifier has no effect for legal counter values.
   assign in_frame   = (hCount < 10'(H_TOTAL)) && (vCount < 10'(V_TOTAL));
   assign start_cond = in_frame && (hCount == 10'd0) && (vCount == 10'd0);
   assign blank_cond = in_frame && (hCount == 10'd0) && (vCount == 10'(V_BLANK_START));
   // upd_ready is a flop that mirrors (state == OPEN), so this has no
   // combinational path from upd_valid to upd_ready.
   assign handshake  = upd_valid && upd_ready;

   // State machine, shadow/live registers and frame counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ACTIVE;
         upd_ready    <= 1'b0;
         sh_p1_x      <= '0;
         sh_p2_x      <= '0;
         sh_p1_pose   <= '0;
         sh_p2_pose   <= '0;
         p1_x         <= '0;
         p2_x         <= '0;
         p1_pose      <= '0;
         p2_pose      <= '0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         committed    <= 1'b0;
         frame_count  <= '0;
         anim_phase   <= '0;
         anim_div     <= '0;
         stale_count  <= '0;
      end else begin
         frame_start  <= start_cond;
         vblank_start <= blank_cond;
         committed    <= 1'b0;

         // The frame counter always runs. The animation divider freezes while paused.
         if (start_cond) begin
            frame_count <= frame_count + 16'd1;
            if (!pause_c) begin
               if (anim_div >= 8'(ANIM_DIV - 1)) begin
                  anim_div   <= '0;
                  anim_phase <= anim_phase + 3'd1;
               end else begin
                  anim_div <= anim_div + 8'd1;
               end
            end
         end

         case (state)
            ACTIVE: begin
               if (start_cond) begin
                  if (!pause_c && (stale_count != 8'hFF))
                     stale_count <= stale_count + 8'd1;
               end else if (blank_cond && !pause_c) begin
                  state     <= OPEN;
                  upd_ready <= 1'b1;
               end
            end

            OPEN: begin
               if (start_cond) begin
                  state     <= ACTIVE;
                  upd_ready <= 1'b0;
                  if (handshake) begin
                     // A late update goes straight to the live registers.
                     p1_x        <= upd_p1_x;
                     p2_x        <= upd_p2_x;
                     p1_pose     <= upd_p1_pose;
                     p2_pose     <= upd_p2_pose;
                     committed   <= 1'b1;
                     stale_count <= '0;
                  end else if (!pause_c && (stale_count != 8'hFF)) begin
                     stale_count <= stale_count + 8'd1;
                  end
               end else if (handshake) begin
                  sh_p1_x    <= upd_p1_x;
                  sh_p2_x    <= upd_p2_x;
                  sh_p1_pose <= upd_p1_pose;
                  sh_p2_pose <= upd_p2_pose;
                  state      <= HELD;
                  upd_ready  <= 1'b0;
               end
            end

            HELD: begin
               if (start_cond) begin
                  p1_x        <= sh_p1_x;
                  p2_x        <= sh_p2_x;
                  p1_pose     <= sh_p1_pose;
                  p2_pose     <= sh_p2_pose;
                  committed   <= 1'b1;
                  stale_count <= '0;
                  state       <= ACTIVE;
               end
            end

            default: begin
               state     <= ACTIVE;
               upd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_sequencer
// Directed bench for vga_frame_sequencer. The scan counters are driven
// directly: (0,0) is a frame start, (0,515) opens the window, and (5,100)
// is an idle position inside the visible region. A table of vectors covers
// the handshake and commit paths. Hand-written sequences then cover counter
// wrap, stale saturation, asynchronous reset and (optionally) pause.
// ---------------------------------------------------------------------------
module tb_vga_frame_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hCount, vCount;
   logic        upd_valid, upd_ready;
   logic [9:0]  upd_p1_x, upd_p2_x;
   logic [2:0]  upd_p1_pose, upd_p2_pose;
   logic [9:0]  p1_x, p2_x;
   logic [2:0]  p1_pose, p2_pose;
   logic        frame_start, vblank_start, committed;
   logic [15:0] frame_count;
   logic [2:0]  anim_phase;
   logic [7:0]  stale_count;
`ifdef VGA_SEQ_PAUSE_EN
   logic        pause = 1'b0;
`endif

   always #5 clk = ~clk;

   vga_frame_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .hCount       (hCount),
      .vCount       (vCount),
`ifdef VGA_SEQ_PAUSE_EN
      .pause        (pause),
`endif
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .upd_p1_x     (upd_p1_x),
      .upd_p2_x     (upd_p2_x),
      .upd_p1_pose  (upd_p1_pose),
      .upd_p2_pose  (upd_p2_pose),
      .p1_x         (p1_x),
      .p2_x         (p2_x),
      .p1_pose      (p1_pose),
      .p2_pose      (p2_pose),
      .frame_start  (frame_start),
      .vblank_start (vblank_start),
      .committed    (committed),
      .frame_count  (frame_count),
      .anim_phase   (anim_phase),
      .stale_count  (stale_count)
   );

   typedef struct {
      logic [9:0]  h, v;
      logic        vld;
      logic [9:0]  x1, x2;
      logic [2:0]  s1, s2;
      logic        rdy, fs, vb, cm;
      logic [9:0]  ex1, ex2;
      logic [2:0]  es1, es2;
      logic [15:0] fc;
      logic [7:0]  st;
   } vec_t;

   vec_t tbl [20];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model for the counters, advanced by the bench.
   int   fc_m    = 0;   // frame starts since reset
   int   anim_m  = 0;   // frame starts that advance the animation
   int   stale_m = 0;

   function automatic vec_t mk(input int h, v, vld, x1, x2, s1, s2,
                               input int rdy, fs, vb, cm,
                               input int e1, e2, es1, es2, fc, st);
      vec_t r;
      r.h = 10'(h);    r.v = 10'(v);    r.vld = 1'(vld);
      r.x1 = 10'(x1);  r.x2 = 10'(x2);  r.s1 = 3'(s1);   r.s2 = 3'(s2);
      r.rdy = 1'(rdy); r.fs = 1'(fs);   r.vb = 1'(vb);   r.cm = 1'(cm);
      r.ex1 = 10'(e1); r.ex2 = 10'(e2); r.es1 = 3'(es1); r.es2 = 3'(es2);
      r.fc = 16'(fc);  r.st = 8'(st);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic drive(input int h, v, vld, x1, x2, s1, s2);
      hCount      = 10'(h);
      vCount      = 10'(v);
      upd_valid   = 1'(vld);
      upd_p1_x    = 10'(x1);
      upd_p2_x    = 10'(x2);
      upd_p1_pose = 3'(s1);
      upd_p2_pose = 3'(s2);
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the counters at (0,0) for n clocks. Each clock is one frame start.
   task automatic dwell_start(input int n);
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         step();
         fc_m++;
         anim_m++;
         if (stale_m < 255) stale_m++;
      end
      drive(5, 100, 0, 0, 0, 0, 0);
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_frame_count"}, 32'(frame_count), 32'(fc_m % 65536));
      chk({tag, "_anim_phase"},  32'(anim_phase),  32'((anim_m / 8) % 8));
      chk({tag, "_stale_count"}, 32'(stale_count), 32'(stale_m));
   endtask

   initial begin
      // Vectors: scan position, handshake inputs, expected outputs after the edge.
      //             h   v  vld  x1  x2 s1 s2  rdy fs vb cm  e1  e2 es1 es2 fc st
      tbl[0]  = mk(5, 100, 0,   0,  0, 0, 0,  0, 0, 0, 0,   0,  0, 0, 0,  0, 0);
      tbl[1]  = mk(0,   0, 0,   0,  0, 0, 0,  0, 1, 0, 0,   0,  0, 0, 0,  1, 1);
      tbl[2]  = mk(5, 100, 0,   0,  0, 0, 0,  0, 0, 0, 0,   0,  0, 0, 0,  1, 1);
      tbl[3]  = mk(0, 515, 0,   0,  0, 0, 0,  1, 0, 1, 0,   0,  0, 0, 0,  1, 1);
      tbl[4]  = mk(5, 100, 0,   0,  0, 0, 0,  1, 0, 0, 0,   0,  0, 0, 0,  1, 1);
      tbl[5]  = mk(0,   0, 0,   0,  0, 0, 0,  0, 1, 0, 0,   0,  0, 0, 0,  2, 2);
      tbl[6]  = mk(0, 515, 0,   0,  0, 0, 0,  1, 0, 1, 0,   0,  0, 0, 0,  2, 2);
      tbl[7]  = mk(5, 100, 1, 100,500, 2, 5,  0, 0, 0, 0,   0,  0, 0, 0,  2, 2);
      tbl[8]  = mk(5, 100, 1,   7,  7, 1, 1,  0, 0, 0, 0,   0,  0, 0, 0,  2, 2);
      tbl[9]  = mk(5, 100, 0,   0,  0, 0, 0,  0, 0, 0, 0,   0,  0, 0, 0,  2, 2);
      tbl[10] = mk(0,   0, 0,   0,  0, 0, 0,  0, 1, 0, 1, 100,500, 2, 5,  3, 0);
      tbl[11] = mk(5, 100, 0,   0,  0, 0, 0,  0, 0, 0, 0, 100,500, 2, 5,  3, 0);
      tbl[12] = mk(0, 515, 0,   0,  0, 0, 0,  1, 0, 1, 0, 100,500, 2, 5,  3, 0);
      tbl[13] = mk(0,   0, 1, 321, 11, 1, 6,  0, 1, 0, 1, 321, 11, 1, 6,  4, 0);
      tbl[14] = mk(0,   0, 0,   0,  0, 0, 0,  0, 1, 0, 0, 321, 11, 1, 6,  5, 1);
      tbl[15] = mk(0, 515, 1,  55, 55, 7, 7,  1, 0, 1, 0, 321, 11, 1, 6,  5, 1);
      tbl[16] = mk(0, 515, 0,   0,  0, 0, 0,  1, 0, 1, 0, 321, 11, 1, 6,  5, 1);
      tbl[17] = mk(5, 100, 1,   9,  8, 3, 4,  0, 0, 0, 0, 321, 11, 1, 6,  5, 1);
      tbl[18] = mk(0, 515, 0,   0,  0, 0, 0,  0, 0, 1, 0, 321, 11, 1, 6,  5, 1);
      tbl[19] = mk(0,   0, 0,   0,  0, 0, 0,  0, 1, 0, 1,   9,  8, 3, 4,  6, 0);

      reset = 1'b1;
      drive(5, 100, 0, 0, 0, 0, 0);
      repeat (3) step();
      chk("reset_ready",  32'(upd_ready),   32'd0);
      chk("reset_p1_x",   32'(p1_x),        32'd0);
      chk("reset_frames", 32'(frame_count), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         drive(32'(tbl[i].h), 32'(tbl[i].v), 32'(tbl[i].vld), 32'(tbl[i].x1),
               32'(tbl[i].x2), 32'(tbl[i].s1), 32'(tbl[i].s2));
         step();
         chk($sformatf("v%0d_upd_ready", i),    32'(upd_ready),    32'(tbl[i].rdy));
         chk($sformatf("v%0d_frame_start", i),  32'(frame_start),  32'(tbl[i].fs));
         chk($sformatf("v%0d_vblank_start", i), 32'(vblank_start), 32'(tbl[i].vb));
         chk($sformatf("v%0d_committed", i),    32'(committed),    32'(tbl[i].cm));
         chk($sformatf("v%0d_p1_x", i),         32'(p1_x),         32'(tbl[i].ex1));
         chk($sformatf("v%0d_p2_x", i),         32'(p2_x),         32'(tbl[i].ex2));
         chk($sformatf("v%0d_p1_pose", i),      32'(p1_pose),      32'(tbl[i].es1));
         chk($sformatf("v%0d_p2_pose", i),      32'(p2_pose),      32'(tbl[i].es2));
         chk($sformatf("v%0d_frame_count", i),  32'(frame_count),  32'(tbl[i].fc));
         chk($sformatf("v%0d_stale_count", i),  32'(stale_count),  32'(tbl[i].st));
         chk($sformatf("v%0d_anim_phase", i),   32'(anim_phase),   32'd0);
      end
      fc_m = 6; anim_m = 6; stale_m = 0;

      // Animation phase: frames 7..64 with no updates. The phase wraps 7->0 at frame 64.
      while (fc_m < 64) begin
         dwell_start(1);
         chk_counters($sformatf("anim_f%0d", fc_m));
         step();
      end
      chk("anim_wrap_at_64", 32'(anim_phase), 32'd0);

      // Stale count saturates at 255.
      dwell_start(300);
      chk_counters("stale_sat");
      chk("stale_sat_value", 32'(stale_count), 32'd255);

      // Run the frame counter up to 65535, then wrap it to 0.
      dwell_start(65535 - fc_m);
      chk_counters("fc_max");
      chk("fc_max_value", 32'(frame_count), 32'd65535);
      dwell_start(1);
      chk_counters("fc_wrap");
      chk("frame_start_dwell", 32'(frame_start), 32'd1);

      // Asynchronous reset in HELD with p1_x=200 in the shadow registers.
      step();
      drive(0, 515, 0, 0, 0, 0, 0); step();
      drive(5, 100, 1, 200, 1, 1, 1); step();
      chk("held_ready", 32'(upd_ready), 32'd0);
      drive(5, 100, 0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("arst_ready",       32'(upd_ready),   32'd0);
      chk("arst_frame_count", 32'(frame_count), 32'd0);
      chk("arst_stale",       32'(stale_count), 32'd0);
      chk("arst_anim",        32'(anim_phase),  32'd0);
      chk("arst_p1_x",        32'(p1_x),        32'd0);
      #1 reset = 1'b0;
      fc_m = 0; anim_m = 0; stale_m = 0;
      step();
      dwell_start(1);
      chk("post_rst_committed", 32'(committed), 32'd0);
      chk("post_rst_p1_x",      32'(p1_x),      32'd0);
      chk_counters("post_rst");
      step();

`ifdef VGA_SEQ_PAUSE_EN
      // While paused the window stays closed and the animation and stale counts freeze.
      pause = 1'b1;
      for (int f = 0; f < 2; f++) begin
         drive(0, 515, 0, 0, 0, 0, 0); step();
         chk($sformatf("pause_ready_%0d", f), 32'(upd_ready), 32'd0);
         drive(0, 0, 1, 0, 0, 0, 0); step();
         fc_m++;
         chk_counters($sformatf("pause_f%0d", f));
         drive(5, 100, 0, 0, 0, 0, 0); step();
      end
      // Pausing in HELD still lets the pending commit complete.
      pause = 1'b0;
      drive(0, 515, 0, 0, 0, 0, 0); step();
      drive(5, 100, 1, 77, 2, 3, 4); step();
      pause = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0); step();
      fc_m++; stale_m = 0;
      chk("pause_commit", 32'(committed), 32'd1);
      chk("pause_p1_x",   32'(p1_x),      32'd77);
      chk_counters("pause_commit");
      pause = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
